// File: rtl/starflux_pkg.sv
// Shared types and constants for the starflux bullet path: coordinates, slot record, FSM states.
package starflux_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [7:0] x_t;
  typedef logic [6:0] y_t;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ENEMY  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    x_t   x;
    y_t   y;
  } slot_t;

  typedef enum logic [1:0] {StIdle, StMove, StDraw} state_e;

  // Inclusive box test in 9 bits so a box near the screen edge never wraps.
  function automatic logic in_box(input x_t x, input y_t y, input x_t bx, input y_t by,
                                  input int unsigned w, input int unsigned h);
    logic [8:0] px, py, lx, ly;
    px = {1'b0, x};
    py = {2'b00, y};
    lx = {1'b0, bx};
    ly = {2'b00, by};
    return (px >= lx) && (px <= lx + 9'(w) - 9'd1) &&
           (py >= ly) && (py <= ly + 9'(h) - 9'd1);
  endfunction

endpackage

// File: rtl/fire_arbiter.sv
// Two-requester round-robin grant plus lowest-index free-slot encoder.
module fire_arbiter #(
  parameter int unsigned NumSlots = 8,
  parameter int unsigned IdxW     = $clog2(NumSlots)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req,
  input  logic [NumSlots-1:0] free,
  output logic [1:0]          grant,
  output logic [IdxW-1:0]     slot_idx
);

  logic enemy_first_q;
  logic any_free;

  always_comb begin
    slot_idx = '0;
    any_free = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (free[i]) begin
        slot_idx = IdxW'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    grant = 2'b00;
    if (any_free) begin
      if (req == 2'b11) begin
        grant = enemy_first_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // Last winner drops to lowest priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enemy_first_q <= 1'b0;
    end else if (grant[0]) begin
      enemy_first_q <= 1'b1;
    end else if (grant[1]) begin
      enemy_first_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet slot pool: fire arbitration, per-tick movement/collision and draw streaming.
// Optional per-requester shot cooldown enabled by defining BULLET_COOLDOWN_EN.
module bullet_scheduler
  import starflux_pkg::*;
#(
  parameter int unsigned NumSlots = 8,
  parameter int unsigned ScreenW  = SCREEN_W,
  parameter int unsigned ScreenH  = SCREEN_H,
  parameter int unsigned HitW     = 8,
  parameter int unsigned HitH     = 8
`ifdef BULLET_COOLDOWN_EN
  ,
  parameter int unsigned CooldownTicks = 4
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       player_fire,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  input  logic       enemy_fire,
  input  logic [7:0] enemy_x,
  input  logic [6:0] enemy_y,
  output logic [1:0] fire_ack,
  output logic       draw_valid,
  input  logic       draw_ready,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       draw_owner,
  output logic       player_hit,
  output logic       enemy_hit,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned IdxW = $clog2(NumSlots);
  typedef logic [IdxW-1:0] idx_t;

  state_e state_q;
  idx_t   idx_q;
  slot_t  slots_q [NumSlots];
  logic   tick_pending_q;
  logic   sticky_player_q, sticky_enemy_q;
  logic [1:0] fire_ack_q;
  logic   player_hit_q, enemy_hit_q, frame_done_q;

  logic [NumSlots-1:0] free;
  logic [1:0] eligible;
  logic [1:0] req;
  logic [1:0] grant;
  idx_t       grant_idx;
  slot_t      spawn;
  slot_t      cur, nxt;
  logic       mv_hit_player, mv_hit_enemy;
  logic       idx_last;

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      free[i] = !slots_q[i].valid;
    end
  end

`ifdef BULLET_COOLDOWN_EN
  localparam int unsigned CdW = $clog2(CooldownTicks + 1);
  logic [CdW-1:0] cd_q [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cd_q[0] <= '0;
      cd_q[1] <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (grant[r]) begin
          cd_q[r] <= CdW'(CooldownTicks);
        end else if (tick && (cd_q[r] != '0)) begin
          cd_q[r] <= cd_q[r] - CdW'(1);
        end
      end
    end
  end

  assign eligible = {cd_q[1] == '0, cd_q[0] == '0};
`else
  assign eligible = 2'b11;
`endif

  // A requester still holds its line in the ack cycle; mask it so one request yields one shot.
  assign req = (state_q == StIdle && !tick && !tick_pending_q) ?
               ({enemy_fire, player_fire} & ~fire_ack_q & eligible) : 2'b00;

  fire_arbiter #(
    .NumSlots(NumSlots)
  ) u_fire_arbiter (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .free    (free),
    .grant   (grant),
    .slot_idx(grant_idx)
  );

  always_comb begin
    spawn.valid = 1'b1;
    spawn.owner = grant[1] ? OWNER_ENEMY : OWNER_PLAYER;
    spawn.x     = grant[1] ? enemy_x : player_x;
    spawn.y     = grant[1] ? enemy_y : player_y;
  end

  always_comb begin
    cur           = slots_q[idx_q];
    nxt           = cur;
    mv_hit_player = 1'b0;
    mv_hit_enemy  = 1'b0;
    if (cur.valid) begin
      if ({1'b0, cur.x} >= 9'(ScreenW)) begin
        nxt.valid = 1'b0;
      end else if (cur.owner == OWNER_PLAYER) begin
        if (cur.y == '0) begin
          nxt.valid = 1'b0;
        end else begin
          nxt.y = cur.y - y_t'(1);
          if (in_box(nxt.x, nxt.y, enemy_x, enemy_y, HitW, HitH)) begin
            nxt.valid    = 1'b0;
            mv_hit_enemy = 1'b1;
          end
        end
      end else begin
        if (cur.y == y_t'(ScreenH - 1)) begin
          nxt.valid = 1'b0;
        end else begin
          nxt.y = cur.y + y_t'(1);
          if (in_box(nxt.x, nxt.y, player_x, player_y, HitW, HitH)) begin
            nxt.valid     = 1'b0;
            mv_hit_player = 1'b1;
          end
        end
      end
    end
  end

  assign idx_last = (idx_q == idx_t'(NumSlots - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      tick_pending_q  <= 1'b0;
      sticky_player_q <= 1'b0;
      sticky_enemy_q  <= 1'b0;
      fire_ack_q      <= 2'b00;
      player_hit_q    <= 1'b0;
      enemy_hit_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      fire_ack_q   <= grant;
      player_hit_q <= 1'b0;
      enemy_hit_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q != StIdle && tick) begin
        tick_pending_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (tick || tick_pending_q) begin
            tick_pending_q <= 1'b0;
            idx_q          <= '0;
            state_q        <= StMove;
          end else if (grant != 2'b00) begin
            slots_q[grant_idx] <= spawn;
          end
        end
        StMove: begin
          slots_q[idx_q] <= nxt;
          if (idx_last) begin
            state_q         <= StDraw;
            idx_q           <= '0;
            player_hit_q    <= sticky_player_q | mv_hit_player;
            enemy_hit_q     <= sticky_enemy_q | mv_hit_enemy;
            sticky_player_q <= 1'b0;
            sticky_enemy_q  <= 1'b0;
          end else begin
            idx_q           <= idx_q + idx_t'(1);
            sticky_player_q <= sticky_player_q | mv_hit_player;
            sticky_enemy_q  <= sticky_enemy_q | mv_hit_enemy;
          end
        end
        StDraw: begin
          if (!slots_q[idx_q].valid || draw_ready) begin
            if (idx_last) begin
              state_q      <= StIdle;
              idx_q        <= '0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + idx_t'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slots are frozen during DRAW, so the pixel stays stable while the plotter stalls.
  assign draw_valid = (state_q == StDraw) && slots_q[idx_q].valid;
  assign draw_x     = slots_q[idx_q].x;
  assign draw_y     = slots_q[idx_q].y;
  assign draw_owner = slots_q[idx_q].owner;
  assign fire_ack   = fire_ack_q;
  assign player_hit = player_hit_q;
  assign enemy_hit  = enemy_hit_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

endmodule
